// File: rtl/alu_pkg.sv
// Shared encodings for the 16-bit alu and the mult_seq controller that drives it.
package alu_pkg;

  // alu opcodes (i_control)
  localparam logic [2:0] OP_SUMA    = 3'b000;
  localparam logic [2:0] OP_SHIFT_D = 3'b001;
  localparam logic [2:0] OP_RESTA   = 3'b010;
  localparam logic [2:0] OP_SHIFT_I = 3'b011;
  localparam logic [2:0] OP_PASAR_B = 3'b100;
  localparam logic [2:0] OP_PASAR_A = 3'b101;

  // mult_seq controller states
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ADD   = 2'b01,
    SHIFT = 2'b10,
    DONE  = 2'b11
  } mult_state_t;

endpackage

// File: rtl/alu.sv
// Combinational 16-bit alu; mayor is the carry out of suma.
module alu
  import alu_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic [2:0]   i_control,
  output logic [N-1:0] q,
  output logic         mayor
);

  // opcode decode
  always_comb begin
    q     = '0;
    mayor = 1'b0;
    case (i_control)
      OP_SUMA:    {mayor, q} = {1'b0, i_a} + {1'b0, i_b};
      OP_RESTA:   q = i_a - i_b;
      OP_SHIFT_D: q = i_a >> 1;
      OP_SHIFT_I: q = i_a << 1;
      OP_PASAR_B: q = i_b;
      OP_PASAR_A: q = i_a;
      default:    q = '0;
    endcase
  end

endmodule

// File: rtl/mult_seq.sv
// Shift-add unsigned multiplier controller that borrows an external alu for
// every add and shift; one ADD and one SHIFT step per multiplier bit.
module mult_seq
  import alu_pkg::*;
#(
  parameter int N  = 16,
  parameter int CW = 5
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_start,
  input  logic [N-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  output logic [N-1:0]   o_alu_a,
  output logic [N-1:0]   o_alu_b,
  output logic [2:0]     o_alu_ctrl,
  input  logic [N-1:0]   i_alu_q,
  input  logic           i_alu_mayor,
  output logic           o_busy,
  output logic           o_done,
  output logic [2*N-1:0] o_prod,
  output logic           o_zero
);

  mult_state_t state_reg, state_next;

  logic [N-1:0]   m_reg;
  logic [N-1:0]   p_hi_reg;
  logic [N-1:0]   p_lo_reg;
  logic           c_reg;
  logic [CW-1:0]  cnt_reg;
  logic [2*N-1:0] prod_reg;
  logic           zero_reg;

  // The alu's shift_d result loses its msb: the saved carry takes that place.
  logic [N-1:0] hi_shift;
  logic [N-1:0] lo_shift;
  logic         last_step;
  logic         unused_alu_msb;

  assign hi_shift       = {c_reg, i_alu_q[N-2:0]};
  assign lo_shift       = {p_hi_reg[0], p_lo_reg[N-1:1]};
  assign last_step      = (cnt_reg == CW'(N-1));
  assign unused_alu_msb = i_alu_q[N-1];

  // state register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // next-state logic; start is only looked at in IDLE
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (i_start) state_next = ADD;
      ADD:     state_next = SHIFT;
      SHIFT:   state_next = last_step ? DONE : ADD;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // alu operand/opcode drive and status outputs, purely from state and registers
  always_comb begin
    o_alu_a    = p_hi_reg;
    o_alu_b    = m_reg;
    o_alu_ctrl = OP_PASAR_A;
    o_busy     = (state_reg != IDLE);
    o_done     = (state_reg == DONE);
    case (state_reg)
      ADD:     o_alu_ctrl = p_lo_reg[0] ? OP_SUMA : OP_PASAR_A;
      SHIFT:   o_alu_ctrl = OP_SHIFT_D;
      default: o_alu_ctrl = OP_PASAR_A;
    endcase
  end

  assign o_prod = prod_reg;
  assign o_zero = zero_reg;

  // datapath registers: load on start, accumulate in ADD, shift in SHIFT
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      m_reg    <= '0;
      p_hi_reg <= '0;
      p_lo_reg <= '0;
      c_reg    <= 1'b0;
      cnt_reg  <= '0;
      prod_reg <= '0;
      zero_reg <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_start) begin
            m_reg    <= i_a;
            p_hi_reg <= '0;
            p_lo_reg <= i_b;
            c_reg    <= 1'b0;
            cnt_reg  <= '0;
          end
        end
        ADD: begin
          p_hi_reg <= i_alu_q;
          c_reg    <= p_lo_reg[0] ? i_alu_mayor : 1'b0;
        end
        SHIFT: begin
          p_hi_reg <= hi_shift;
          p_lo_reg <= lo_shift;
          c_reg    <= 1'b0;
          cnt_reg  <= cnt_reg + 1'b1;
          // the product is published only as DONE is entered
          if (last_step) begin
            prod_reg <= {hi_shift, lo_shift};
            zero_reg <= ({hi_shift, lo_shift} == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq.sv
// Directed bench for mult_seq wired to the real alu.
module tb_mult_seq;
  import alu_pkg::*;

  localparam int N = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [N-1:0]   a, b;
  logic [N-1:0]   alu_a, alu_b, alu_q;
  logic [2:0]     alu_ctrl;
  logic           alu_mayor;
  logic           busy, done, zero;
  logic [2*N-1:0] prod;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mult_seq #(.N(N), .CW(5)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_start     (start),
    .i_a         (a),
    .i_b         (b),
    .o_alu_a     (alu_a),
    .o_alu_b     (alu_b),
    .o_alu_ctrl  (alu_ctrl),
    .i_alu_q     (alu_q),
    .i_alu_mayor (alu_mayor),
    .o_busy      (busy),
    .o_done      (done),
    .o_prod      (prod),
    .o_zero      (zero)
  );

  alu #(.N(N)) u_alu (
    .i_a       (alu_a),
    .i_b       (alu_b),
    .i_control (alu_ctrl),
    .q         (alu_q),
    .mayor     (alu_mayor)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Counts edges until o_done is seen (sampled 1 time unit after each edge).
  // Unless held, start drops after the first edge, optionally re-pulsing at
  // edges 5 and 20 to show those requests are ignored.
  task automatic wait_done(input bit hold, input bit pulse, output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
      if (!hold) start = pulse && (edges == 5 || edges == 20);
    end while (!done && edges < 200);
  endtask

  task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb_,
                        input logic [2*N-1:0] exp, input string tag);
    int edges;
    a = ta; b = tb_; start = 1'b1;
    wait_done(1'b0, 1'b0, edges);
    check({tag, " latency"}, 64'(edges), 64'd33);
    check({tag, " prod"}, 64'(prod), 64'(exp));
    check({tag, " zero"}, 64'(zero), 64'(exp == '0));
    @(posedge clk); #1;
    check({tag, " done drop"}, 64'(done), 64'd0);
    check({tag, " busy drop"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int edges;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst prod", 64'(prod), 64'd0);
    check("rst zero", 64'(zero), 64'd1);
    check("rst alu_a", 64'(alu_a), 64'd0);
    check("rst alu_b", 64'(alu_b), 64'd0);
    check("rst alu_ctrl", 64'(alu_ctrl), 64'd5);
    rst = 1'b0;
    @(posedge clk); #1;

    // 3*5 with a look at the first ADD step
    a = 16'd3; b = 16'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("3x5 busy", 64'(busy), 64'd1);
    check("3x5 add ctrl", 64'(alu_ctrl), 64'd0);
    check("3x5 add alu_b", 64'(alu_b), 64'd3);
    wait_done(1'b0, 1'b0, edges);
    check("3x5 latency", 64'(edges + 1), 64'd33);
    check("3x5 prod", 64'(prod), 64'h0000_000F);
    check("3x5 zero", 64'(zero), 64'd0);
    @(posedge clk); #1;
    check("3x5 busy drop", 64'(busy), 64'd0);

    run_op(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, "ffffxffff");
    run_op(16'h1234, 16'h0000, 32'h0000_0000, "1234x0");
    run_op(16'h8000, 16'h0002, 32'h0001_0000, "8000x2");

    // 7*9 with stray start pulses, then a start during DONE
    a = 16'd7; b = 16'd9; start = 1'b1;
    wait_done(1'b0, 1'b1, edges);
    check("7x9 latency", 64'(edges), 64'd33);
    check("7x9 prod", 64'(prod), 64'd63);
    start = 1'b1;
    @(posedge clk); #1;
    check("start in done busy", 64'(busy), 64'd0);
    start = 1'b0;
    @(posedge clk); #1;
    check("start in done idle", 64'(busy), 64'd0);

    // asynchronous reset mid-operation
    a = 16'd7; b = 16'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort prod", 64'(prod), 64'd0);
    check("abort zero", 64'(zero), 64'd1);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    run_op(16'd2, 16'd2, 32'd4, "2x2");

    // back-to-back with start held high
    a = 16'd1; b = 16'd1; start = 1'b1;
    wait_done(1'b1, 1'b0, edges);
    check("b2b1 latency", 64'(edges), 64'd33);
    check("b2b1 prod", 64'(prod), 64'd1);
    a = 16'h00FF; b = 16'h0100;
    @(posedge clk); #1;
    check("b2b idle busy", 64'(busy), 64'd0);
    wait_done(1'b1, 1'b0, edges);
    check("b2b2 latency", 64'(edges), 64'd33);
    check("b2b2 prod", 64'(prod), 64'h0000_FF00);
    check("b2b2 zero", 64'(zero), 64'd0);
    start = 1'b0;
    @(posedge clk); #1;
    check("b2b2 busy drop", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
